// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead add/subtract unit.
package adder_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    ADC = 2'd2,
    SBB = 2'd3
  } op_e;

  // Carry injected into bit 0: subtraction is A + ~B + 1, and SBB takes the inverted borrow.
  function automatic logic cin_for_op(input op_e op, input logic cin);
    logic c;
    case (op)
      ADD:     c = 1'b0;
      SUB:     c = 1'b1;
      ADC:     c = cin;
      SBB:     c = ~cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  function automatic bit width_ok(input int unsigned w, input int unsigned ns,
                                  input int unsigned seg);
    return (ns != 0) && (seg != 0) && (w != 0) && ((w % (ns * seg)) == 0);
  endfunction

endpackage

// File: rtl/cla_chunk.sv
// Combinational W-bit carry-lookahead adder built from SEG-bit generate/propagate groups.
module cla_chunk #(
  parameter int unsigned W   = 8,
  parameter int unsigned SEG = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  localparam int unsigned NGRP = W / SEG;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         gg;
  logic         gp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry inside a group is formed directly from the group carry-in via the
  // running prefix generate/propagate; groups then ripple into each other.
  always_comb begin
    c    = '0;
    gg   = 1'b0;
    gp   = 1'b1;
    c[0] = cin;
    for (int unsigned j = 0; j < NGRP; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int unsigned i = 0; i < SEG; i++) begin
        gg = g[j*SEG+i] | (p[j*SEG+i] & gg);
        gp = gp & p[j*SEG+i];
        c[j*SEG+i+1] = gg | (gp & c[j*SEG]);
      end
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];
  assign cmsb = c[W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined ADD/SUB/ADC/SBB unit, one CHUNK-wide lookahead slice per stage, valid/ready flow.
// Optional signed saturation enabled by defining PIPELINED_CLA_ADDER_SAT_EN (adds in_sat).
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NSTAGE = 4,
  parameter int unsigned SEG    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
`ifdef PIPELINED_CLA_ADDER_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned CHUNK = WIDTH / NSTAGE;

  if (!width_ok(WIDTH, NSTAGE, SEG)) begin : g_cfg_err
    $error("pipelined_cla_adder: WIDTH must be a multiple of NSTAGE*SEG");
  end

  function automatic logic [WIDTH-1:0] put_chunk(input logic [WIDTH-1:0] base,
                                                 input logic [CHUNK-1:0] c,
                                                 input int unsigned k);
    logic [WIDTH-1:0] r;
    r = base;
    r[k*CHUNK +: CHUNK] = c;
    return r;
  endfunction

  op_e              op_in;
  logic [WIDTH-1:0] bp;
  logic             c0;
  logic             adv;

  // Per-stage registers: operands skewed forward, partial sum, chunk carry.
  logic             vld [NSTAGE];
  logic [WIDTH-1:0] ar  [NSTAGE];
  logic [WIDTH-1:0] br  [NSTAGE];
  logic [WIDTH-1:0] sr  [NSTAGE];
  logic             cy  [NSTAGE];
  logic             ovf_r;

  // Per-stage combinational slice inputs/outputs.
  logic [CHUNK-1:0] ca  [NSTAGE];
  logic [CHUNK-1:0] cb  [NSTAGE];
  logic             ci  [NSTAGE];
  logic [CHUNK-1:0] cs  [NSTAGE];
  logic             co  [NSTAGE];
  logic             cm  [NSTAGE];
  logic [WIDTH-1:0] nxt [NSTAGE];

  logic [WIDTH-1:0] fin_sum;
  logic             fin_ovf;

  assign op_in    = op_e'(in_op);
  assign bp       = (op_in == SUB || op_in == SBB) ? ~in_b : in_b;
  assign c0       = cin_for_op(op_in, in_cin);
  assign adv      = !vld[NSTAGE-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign ca[k]  = in_a[0 +: CHUNK];
      assign cb[k]  = bp[0 +: CHUNK];
      assign ci[k]  = c0;
      assign nxt[k] = put_chunk('0, cs[k], k);
    end else begin : g_body
      assign ca[k]  = ar[k-1][k*CHUNK +: CHUNK];
      assign cb[k]  = br[k-1][k*CHUNK +: CHUNK];
      assign ci[k]  = cy[k-1];
      assign nxt[k] = put_chunk(sr[k-1], cs[k], k);
    end

    cla_chunk #(
      .W   (CHUNK),
      .SEG (SEG)
    ) u_chunk (
      .a    (ca[k]),
      .b    (cb[k]),
      .cin  (ci[k]),
      .sum  (cs[k]),
      .cout (co[k]),
      .cmsb (cm[k])
    );
  end

  assign fin_ovf = co[NSTAGE-1] ^ cm[NSTAGE-1];

`ifdef PIPELINED_CLA_ADDER_SAT_EN
  logic st [NSTAGE];
  logic sat_last;

  if (NSTAGE == 1) begin : g_sat_direct
    assign sat_last = in_sat;
  end else begin : g_sat_piped
    assign sat_last = st[NSTAGE-2];
  end

  // Wrapped MSB set on overflow means the true result was positive.
  always_comb begin
    fin_sum = nxt[NSTAGE-1];
    if (sat_last && fin_ovf) begin
      fin_sum = nxt[NSTAGE-1][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                       : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && adv) begin
      st[0] <= in_sat;
      for (int unsigned k = 1; k < NSTAGE; k++) st[k] <= st[k-1];
    end
  end
`else
  assign fin_sum = nxt[NSTAGE-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSTAGE; k++) vld[k] <= 1'b0;
      sr[NSTAGE-1] <= '0;
      cy[NSTAGE-1] <= 1'b0;
      ovf_r        <= 1'b0;
    end else if (adv) begin
      vld[0] <= in_valid;
      ar[0]  <= in_a;
      br[0]  <= bp;
      for (int unsigned k = 1; k < NSTAGE; k++) begin
        vld[k] <= vld[k-1];
        ar[k]  <= ar[k-1];
        br[k]  <= br[k-1];
      end
      for (int unsigned k = 0; k + 1 < NSTAGE; k++) sr[k] <= nxt[k];
      for (int unsigned k = 0; k < NSTAGE; k++) cy[k] <= co[k];
      sr[NSTAGE-1] <= fin_sum;
      ovf_r        <= fin_ovf;
    end
  end

  assign out_valid = vld[NSTAGE-1];
  assign out_sum   = sr[NSTAGE-1];
  assign out_carry = cy[NSTAGE-1];
  assign out_ovf   = ovf_r;
  assign out_zero  = vld[NSTAGE-1] && (sr[NSTAGE-1] == '0);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=32, NSTAGE=4, SEG=4); scoreboard of hand-computed results.
module tb_pipelined_cla_adder;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_ADC = 2'd2;
  localparam logic [1:0] OP_SBB = 2'd3;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic        in_cin;
  logic        in_sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;

  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned cyc;
  exp_t        exp_q[$];
  int unsigned emit_cyc[$];
  exp_t        me;

  pipelined_cla_adder #(
    .WIDTH  (32),
    .NSTAGE (4),
    .SEG    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
`ifdef PIPELINED_CLA_ADDER_SAT_EN
    .in_sat    (in_sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard: compares every emitted result, and the held value during a stall.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else if (out_ready) begin
        me = exp_q.pop_front();
        check("sum",   out_sum, me.sum);
        check("carry", {31'd0, out_carry}, {31'd0, me.c});
        check("ovf",   {31'd0, out_ovf},   {31'd0, me.v});
        check("zero",  {31'd0, out_zero},  {31'd0, me.z});
        emit_cyc.push_back(cyc);
      end else begin
        check("stall_hold", out_sum, exp_q[0].sum);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sat, input logic [31:0] es,
                      input logic ec, input logic ev, output int unsigned stalls);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sat   = sat;
    stalls   = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    e.sum = es;
    e.c   = ec;
    e.v   = ev;
    e.z   = (es == 32'd0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_due"}, {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned st;
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = OP_ADD;
    in_cin    = 1'b0;
    in_sat    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum",   out_sum, 32'd0);
    check("rst_out_carry", {31'd0, out_carry}, 32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf}, 32'd0);
    check("rst_out_zero",  {31'd0, out_zero}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Single op with latency measurement: FFFFFFFF + 1 wraps to zero.
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, st);
    check_latency("lat_add");
    drain();

    // Directed arithmetic vectors, issued back to back.
    send(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, st);
    send(OP_ADC, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, st);
    send(OP_SBB, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 1'b0, st);
    send(OP_SBB, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0002, 1'b1, 1'b0, st);
    send(OP_ADC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, st);
    send(OP_SUB, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, st);
    send(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, st);
    send(OP_SUB, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, st);
    send(OP_ADD, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, st);
    send(OP_ADD, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, st);
    send(OP_SUB, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0, st);
    drain();

    // Streaming: i + 10*i on consecutive cycles, no input stalls, consecutive outputs.
    emit_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(OP_ADD, i, 10 * i, 1'b0, 1'b0, 11 * i, 1'b0, 1'b0, st);
      check("stream_no_stall", st, 32'd0);
    end
    drain();
    check("stream_count", emit_cyc.size(), 32'd8);
    for (int i = 1; i < 8; i++)
      if (emit_cyc.size() > i) check("stream_consec", emit_cyc[i] - emit_cyc[0], i);

    // Backpressure: 3-cycle stall mid-burst.
    for (int i = 0; i < 5; i++)
      send(OP_ADD, 100 + i, i, 1'b0, 1'b0, 100 + 2 * i, 1'b0, 1'b0, st);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 5; i < 8; i++)
      send(OP_ADD, 100 + i, i, 1'b0, 1'b0, 100 + 2 * i, 1'b0, 1'b0, st);
    drain();

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++)
      send(OP_ADD, 32'h10 + i, 32'h1, 1'b0, 1'b0, 32'h11 + i, 1'b0, 1'b0, st);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_sum",   out_sum, 32'd0);
    check("mid_rst_out_carry", {31'd0, out_carry}, 32'd0);
    check("mid_rst_out_ovf",   {31'd0, out_ovf}, 32'd0);
    check("mid_rst_out_zero",  {31'd0, out_zero}, 32'd0);
    check("mid_rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(OP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, st);
    check_latency("lat_after_rst");
    drain();

`ifdef PIPELINED_CLA_ADDER_SAT_EN
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, st);
    send(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, st);
    send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, st);
    send(OP_ADD, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0, st);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
